// File: rtl/cache_set_unit.sv
// Single-line cache set storage for the TTCache way controller.
// Holds one line (tag, valid, dirty, four 16-bit words) and services
// compare/access read/write requests over a level enable/ack handshake.
// It also carries a free-running 5-bit Fibonacci LFSR that the way
// controller uses for random victim selection.
module cache_set_unit #(
    parameter int         WORDS     = 4,
    parameter logic [4:0] LFSR_SEED = 5'b00001
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [1:0]  i_word,
    input  logic        i_comp,
    input  logic        i_write,
    input  logic [4:0]  i_tag_in,
    input  logic [15:0] i_data_in,
    input  logic        i_valid_in,
    output logic        o_hit,
    output logic        o_dirty_out,
    output logic [4:0]  o_tag_out,
    output logic [15:0] o_data_out,
    output logic        o_valid_out,
    output logic        o_ack,
    input  logic        i_rand_en,
    output logic [4:0]  o_rand
);

    typedef enum logic {S_IDLE, S_DONE} state_t;

    state_t                   r_state;
    logic                     r_valid;
    logic                     r_dirty;
    logic [4:0]               r_tag;
    logic [WORDS-1:0][15:0]   r_words;
    logic                     r_hit;
    logic                     r_dirty_out;
    logic [4:0]               r_tag_out;
    logic [15:0]              r_data_out;
    logic                     r_valid_out;
    logic                     r_ack;
    logic [4:0]               r_lfsr;

    logic                     w_match;
    logic                     w_fb;

    assign w_match = r_valid && (r_tag == i_tag_in);
    assign w_fb    = r_lfsr[4] ^ r_lfsr[2];

    // Request FSM: one operation per enable assertion, all outputs registered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_valid     <= 1'b0;
            r_dirty     <= 1'b0;
            r_tag       <= '0;
            r_words     <= '0;
            r_hit       <= 1'b0;
            r_dirty_out <= 1'b0;
            r_tag_out   <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_ack       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_enable) begin
                        r_ack       <= 1'b1;
                        r_state     <= S_DONE;
                        // Default: report the stored line unchanged
                        r_hit       <= 1'b0;
                        r_dirty_out <= r_dirty;
                        r_tag_out   <= r_tag;
                        r_data_out  <= r_words[i_word];
                        r_valid_out <= r_valid;
                        if (i_comp) begin
                            r_hit <= w_match;
                            // Compare write only lands on a hit; a miss leaves the line alone
                            if (i_write && w_match) begin
                                r_words[i_word] <= i_data_in;
                                r_dirty         <= 1'b1;
                                r_dirty_out     <= 1'b1;
                                r_data_out      <= i_data_in;
                            end
                        end else if (i_write) begin
                            // Access write refills the line identity; other words untouched
                            r_words[i_word] <= i_data_in;
                            r_tag           <= i_tag_in;
                            r_valid         <= i_valid_in;
                            r_dirty         <= 1'b0;
                            r_data_out      <= i_data_in;
                            r_tag_out       <= i_tag_in;
                            r_valid_out     <= i_valid_in;
                            r_dirty_out     <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    // Hold results until the requester drops enable
                    if (!i_enable) begin
                        r_ack   <= 1'b0;
                        r_hit   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Victim-select LFSR, x^5+x^3+1, advances only when enabled
    always_ff @(posedge i_clk) begin
        if (i_rst)          r_lfsr <= LFSR_SEED;
        else if (i_rand_en) r_lfsr <= {r_lfsr[3:0], w_fb};
    end

    assign o_hit       = r_hit;
    assign o_dirty_out = r_dirty_out;
    assign o_tag_out   = r_tag_out;
    assign o_data_out  = r_data_out;
    assign o_valid_out = r_valid_out;
    assign o_ack       = r_ack;
    assign o_rand      = r_lfsr;

endmodule

// File: tb/tb_cache_set_unit.sv
// Scoreboard bench for cache_set_unit: the driver pushes hand-computed
// responses, a monitor pops and compares on each rising ack.
module tb_cache_set_unit;

    typedef struct packed {
        logic        hit;
        logic        dirty;
        logic [4:0]  tag;
        logic [15:0] data;
        logic        valid;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_enable = 1'b0;
    logic [1:0]  i_word = '0;
    logic        i_comp = 1'b0;
    logic        i_write = 1'b0;
    logic [4:0]  i_tag_in = '0;
    logic [15:0] i_data_in = '0;
    logic        i_valid_in = 1'b0;
    logic        o_hit, o_dirty_out, o_valid_out, o_ack;
    logic [4:0]  o_tag_out, o_rand;
    logic [15:0] o_data_out;
    logic        i_rand_en = 1'b0;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    logic prev_ack = 1'b0;

    cache_set_unit #(.WORDS(4), .LFSR_SEED(5'b00001)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_word(i_word),
        .i_comp(i_comp), .i_write(i_write), .i_tag_in(i_tag_in),
        .i_data_in(i_data_in), .i_valid_in(i_valid_in), .o_hit(o_hit),
        .o_dirty_out(o_dirty_out), .o_tag_out(o_tag_out), .o_data_out(o_data_out),
        .o_valid_out(o_valid_out), .o_ack(o_ack), .i_rand_en(i_rand_en),
        .o_rand(o_rand)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare against the scoreboard on each new ack
    always @(negedge i_clk) begin
        if (o_ack && !prev_ack) begin
            exp_t e;
            exp_t a;
            a = '{hit:o_hit, dirty:o_dirty_out, tag:o_tag_out, data:o_data_out, valid:o_valid_out};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ack: got %h expected none", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_err++;
                    $display("FAIL resp: got hit=%b dirty=%b tag=%h data=%h valid=%b expected hit=%b dirty=%b tag=%h data=%h valid=%b",
                             a.hit, a.dirty, a.tag, a.data, a.valid, e.hit, e.dirty, e.tag, e.data, e.valid);
                end
            end
        end
        prev_ack <= o_ack;
    end

    task automatic start(input bit c, input bit w, input logic [1:0] wd,
                         input logic [4:0] t, input logic [15:0] d, input bit vin,
                         input exp_t e);
        exp_q.push_back(e);
        i_comp = c; i_write = w; i_word = wd; i_tag_in = t;
        i_data_in = d; i_valid_in = vin; i_enable = 1'b1;
    endtask

    task automatic wait_ack();
        bit got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge i_clk);
            got = o_ack;
        end
        chk("ack_seen", {31'b0, got}, 32'd1);
    endtask

    task automatic drop();
        i_enable = 1'b0;
        @(negedge i_clk);
        chk("ack_drop", {31'b0, o_ack}, 32'd0);
        chk("hit_drop", {31'b0, o_hit}, 32'd0);
    endtask

    task automatic op(input bit c, input bit w, input logic [1:0] wd,
                      input logic [4:0] t, input logic [15:0] d, input bit vin,
                      input exp_t e);
        start(c, w, wd, t, d, vin, e);
        wait_ack();
        drop();
    endtask

    function automatic exp_t mk(bit h, bit dy, logic [4:0] t, logic [15:0] d, bit v);
        return '{hit:h, dirty:dy, tag:t, data:d, valid:v};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] lfsr_tab [5];
        lfsr_tab = '{5'b00010, 5'b00100, 5'b01001, 5'b10010, 5'b00101};

        // Reset state
        repeat (2) @(negedge i_clk);
        chk("rst_ack",   {31'b0, o_ack}, 32'd0);
        chk("rst_hit",   {31'b0, o_hit}, 32'd0);
        chk("rst_valid", {31'b0, o_valid_out}, 32'd0);
        chk("rst_data",  {16'b0, o_data_out}, 32'd0);
        chk("rst_rand",  {27'b0, o_rand}, 32'd1);
        i_rst = 1'b0;

        // LFSR sequence, full period, hold
        i_rand_en = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            @(negedge i_clk);
            if (i <= 5) chk("lfsr_seq", {27'b0, o_rand}, {27'b0, lfsr_tab[i-1]});
            if (o_rand == 5'd0) chk("lfsr_nonzero", {27'b0, o_rand}, 32'd1);
        end
        chk("lfsr_period", {27'b0, o_rand}, 32'd1);
        i_rand_en = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("lfsr_hold", {27'b0, o_rand}, 32'd1);

        // Cache operations on a freshly reset line
        op(0, 0, 2'd0, 5'h00, 16'h0000, 0, mk(0, 0, 5'h00, 16'h0000, 0));
        op(0, 1, 2'd2, 5'h0A, 16'hBEEF, 1, mk(0, 0, 5'h0A, 16'hBEEF, 1));
        op(1, 0, 2'd2, 5'h0A, 16'h0000, 0, mk(1, 0, 5'h0A, 16'hBEEF, 1));
        op(1, 1, 2'd1, 5'h0A, 16'h1234, 0, mk(1, 1, 5'h0A, 16'h1234, 1));
        op(0, 0, 2'd1, 5'h00, 16'h0000, 0, mk(0, 1, 5'h0A, 16'h1234, 1));
        op(1, 1, 2'd1, 5'h0B, 16'h5555, 0, mk(0, 1, 5'h0A, 16'h1234, 1));
        op(0, 0, 2'd1, 5'h00, 16'h0000, 0, mk(0, 1, 5'h0A, 16'h1234, 1));
        op(0, 0, 2'd2, 5'h00, 16'h0000, 0, mk(0, 1, 5'h0A, 16'hBEEF, 1));
        op(0, 1, 2'd0, 5'h0A, 16'h0F0F, 0, mk(0, 0, 5'h0A, 16'h0F0F, 0));
        op(1, 0, 2'd0, 5'h0A, 16'h0000, 0, mk(0, 0, 5'h0A, 16'h0F0F, 0));

        // Held enable: one operation, inputs ignored during DONE
        start(0, 1, 2'd3, 5'h03, 16'h1111, 1, mk(0, 0, 5'h03, 16'h1111, 1));
        wait_ack();
        i_data_in = 16'h2222; i_tag_in = 5'h1F; i_word = 2'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            chk("hold_ack",  {31'b0, o_ack}, 32'd1);
            chk("hold_data", {16'b0, o_data_out}, 32'h1111);
        end
        drop();
        op(0, 0, 2'd3, 5'h00, 16'h0000, 0, mk(0, 0, 5'h03, 16'h1111, 1));
        op(0, 0, 2'd0, 5'h00, 16'h0000, 0, mk(0, 0, 5'h03, 16'h0F0F, 1));
        op(0, 0, 2'd2, 5'h00, 16'h0000, 0, mk(0, 0, 5'h03, 16'hBEEF, 1));

        // Reset while in DONE
        start(0, 1, 2'd1, 5'h07, 16'hABCD, 1, mk(0, 0, 5'h07, 16'hABCD, 1));
        wait_ack();
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("rstdone_ack",   {31'b0, o_ack}, 32'd0);
        chk("rstdone_valid", {31'b0, o_valid_out}, 32'd0);
        i_rst = 1'b0; i_enable = 1'b0;
        @(negedge i_clk);
        op(0, 0, 2'd1, 5'h00, 16'h0000, 0, mk(0, 0, 5'h00, 16'h0000, 0));
        op(1, 0, 2'd1, 5'h00, 16'h0000, 0, mk(0, 0, 5'h00, 16'h0000, 0));

        repeat (2) @(negedge i_clk);
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
